// File: rtl/ahb_cmd_master_if.sv
// ahb_cmd_master_if
// Groups the command/response stream and the AHB-Lite master-side bus signals
// used by ahb_cmd_master. The clock and reset are kept as plain module ports.
//
// Signals
//   cmd_valid/cmd_ready/cmd_addr/cmd_write/cmd_size/cmd_wdata : command stream
//   rsp_valid/rsp_rdata/rsp_err/rsp_cancel                    : response pulse
//   HADDR/HTRANS/HWRITE/HSIZE/HBURST/HMASTLOCK/HWDATA         : AHB master outputs
//   HREADY/HRESP/HRDATA                                       : AHB slave returns
//
// Modports
//   master : view of ahb_cmd_master itself
//   slave  : view of the environment (command source, response sink, bus slave)
interface ahb_cmd_master_if #(
    parameter int ADDR_W = 36,
    parameter int DATA_W = 64
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_write;
    logic [2:0]        cmd_size;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_cancel;

    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic              HMASTLOCK;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic [1:0]        HRESP;
    logic [DATA_W-1:0] HRDATA;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_cancel,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HWDATA,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_cancel,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HWDATA,
        output HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master
// Single-transfer AHB-Lite master. Each accepted command becomes one NONSEQ
// SINGLE transfer; one response pulse is returned per command, in order.
//
// Ports
//   HCLK   : clock, all logic on the rising edge
//   HRESET : synchronous active-high reset
//   bus    : ahb_cmd_master_if.master (command stream, response pulse, AHB bus)
//
// Pipeline
//   A-stage : address phase (HTRANS/HADDR/HWRITE/HSIZE) plus the write data
//             that will be driven in the following data phase.
//   D-stage : data phase (d_valid, d_write, HWDATA).
//   Both stages advance only when HREADY=1. On the first cycle of an ERROR
//   response the A-stage is squashed to IDLE; a squashed command is answered
//   with a cancel response one cycle after the error response.
module ahb_cmd_master #(
    parameter int ADDR_W = 36,
    parameter int DATA_W = 64
) (
    input  logic HCLK,
    input  logic HRESET,
    ahb_cmd_master_if.master bus
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    // A-stage
    logic              a_nonseq_reg;
    logic [ADDR_W-1:0] haddr_reg;
    logic              hwrite_reg;
    logic [2:0]        hsize_reg;
    logic [DATA_W-1:0] a_wdata_reg;

    // D-stage
    logic              d_valid_reg;
    logic              d_write_reg;
    logic [DATA_W-1:0] hwdata_reg;

    // Response
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;
    logic              rsp_err_reg;
    logic              rsp_cancel_reg;
    logic              cancel_pend_reg;

    logic cmd_ready;
    logic accept;
    logic d_done;
    logic err_first;

    // Commands are refused while reset is asserted so nothing slips into the
    // A-stage on the edge reset is released.
    assign cmd_ready = bus.HREADY & ~HRESET;
    assign accept    = bus.cmd_valid & cmd_ready;
    assign d_done    = d_valid_reg & bus.HREADY;
    // First cycle of the two-cycle ERROR response; HRESP is meaningless
    // without a transfer in the data phase.
    assign err_first = d_valid_reg & ~bus.HREADY & (bus.HRESP == HRESP_ERROR);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            a_nonseq_reg    <= 1'b0;
            haddr_reg       <= '0;
            hwrite_reg      <= 1'b0;
            hsize_reg       <= 3'd0;
            a_wdata_reg     <= '0;
            d_valid_reg     <= 1'b0;
            d_write_reg     <= 1'b0;
            hwdata_reg      <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b0;
            rsp_cancel_reg  <= 1'b0;
            cancel_pend_reg <= 1'b0;
        end else begin
            // Response pulse: completion of the data phase has priority. A
            // pending cancel can never collide with it because the A-stage was
            // squashed, so the D-stage is empty the cycle after the error.
            rsp_valid_reg  <= 1'b0;
            rsp_rdata_reg  <= '0;
            rsp_err_reg    <= 1'b0;
            rsp_cancel_reg <= 1'b0;
            if (d_done) begin
                rsp_valid_reg <= 1'b1;
                rsp_rdata_reg <= d_write_reg ? '0 : bus.HRDATA;
                rsp_err_reg   <= (bus.HRESP == HRESP_ERROR);
            end else if (cancel_pend_reg && !d_valid_reg) begin
                rsp_valid_reg   <= 1'b1;
                rsp_err_reg     <= 1'b1;
                rsp_cancel_reg  <= 1'b1;
                cancel_pend_reg <= 1'b0;
            end

            if (bus.HREADY) begin
                d_valid_reg <= a_nonseq_reg;
                d_write_reg <= hwrite_reg;
                hwdata_reg  <= (a_nonseq_reg && hwrite_reg) ? a_wdata_reg : '0;
                if (accept) begin
                    a_nonseq_reg <= 1'b1;
                    haddr_reg    <= bus.cmd_addr;
                    hwrite_reg   <= bus.cmd_write;
                    hsize_reg    <= bus.cmd_size;
                    a_wdata_reg  <= bus.cmd_wdata;
                end else begin
                    // IDLE keeps the last address/control to avoid toggling.
                    a_nonseq_reg <= 1'b0;
                end
            end else if (err_first) begin
                if (a_nonseq_reg) begin
                    cancel_pend_reg <= 1'b1;
                end
                a_nonseq_reg <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_rdata  = rsp_rdata_reg;
    assign bus.rsp_err    = rsp_err_reg;
    assign bus.rsp_cancel = rsp_cancel_reg;
    assign bus.HADDR      = haddr_reg;
    assign bus.HTRANS     = a_nonseq_reg ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HWRITE     = hwrite_reg;
    assign bus.HSIZE      = hsize_reg;
    assign bus.HBURST     = 3'b000;
    assign bus.HMASTLOCK  = 1'b0;
    assign bus.HWDATA     = hwdata_reg;
endmodule

// File: tb/tb_ahb_cmd_master.sv
// tb_ahb_cmd_master
// Directed bench for ahb_cmd_master. Inputs change 1 time unit after a rising
// edge and outputs are sampled at the same point, so "cycle N" below is the
// cycle following edge N-1. Command accepted at edge 0 = cycle 0 drive.
module tb_ahb_cmd_master;
    localparam int ADDR_W = 36;
    localparam int DATA_W = 64;

    logic HCLK;
    logic HRESET;
    int   checks;
    int   failures;

    ahb_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

    ahb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (ifc.master)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_cmd(input logic v, input logic [ADDR_W-1:0] a, input logic w,
                             input logic [2:0] s, input logic [DATA_W-1:0] d);
        ifc.cmd_valid = v;
        ifc.cmd_addr  = a;
        ifc.cmd_write = w;
        ifc.cmd_size  = s;
        ifc.cmd_wdata = d;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        ifc.HREADY = 1'b1;
        drive_cmd(1'b1, 36'h0_0000_0040, 1'b1, 3'd3, 64'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ifc.HTRANS !== 2'b00 || ifc.HADDR !== '0 || ifc.HWRITE !== 1'b0 ||
                ifc.HSIZE !== 3'd0 || ifc.HWDATA !== '0 || ifc.HBURST !== 3'b000 ||
                ifc.HMASTLOCK !== 1'b0) begin
                failures++;
                $display("FAIL reset_bus cyc=%0d htrans=%b haddr=%h hwrite=%b hsize=%0d hwdata=%h exp all zero",
                         i, ifc.HTRANS, ifc.HADDR, ifc.HWRITE, ifc.HSIZE, ifc.HWDATA);
            end
            checks++;
            if (ifc.rsp_valid !== 1'b0 || ifc.rsp_rdata !== '0 || ifc.rsp_err !== 1'b0 ||
                ifc.rsp_cancel !== 1'b0 || ifc.cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_rsp cyc=%0d valid=%b rdata=%h err=%b cancel=%b ready=%b exp 0",
                         i, ifc.rsp_valid, ifc.rsp_rdata, ifc.rsp_err, ifc.rsp_cancel, ifc.cmd_ready);
            end
        end
        drive_cmd(1'b0, '0, 1'b0, 3'd0, '0);
        HRESET = 1'b0;
        tick();
        checks++;
        if (ifc.HTRANS !== 2'b00) begin
            failures++;
            $display("FAIL reset_no_accept htrans=%b exp 00", ifc.HTRANS);
        end
        $display("reset: done");
    endtask

    task automatic test_single_write();
        drive_cmd(1'b1, 36'h0_0000_1000, 1'b1, 3'd3, 64'hDEADBEEF_CAFEF00D);
        tick(); // cycle 1
        drive_cmd(1'b0, '0, 1'b0, 3'd0, '0);
        checks++;
        if (ifc.HTRANS !== 2'b10 || ifc.HADDR !== 36'h0_0000_1000 || ifc.HWRITE !== 1'b1 ||
            ifc.HSIZE !== 3'd3) begin
            failures++;
            $display("FAIL wr_addr htrans=%b haddr=%h hwrite=%b hsize=%0d exp 10/1000/1/3",
                     ifc.HTRANS, ifc.HADDR, ifc.HWRITE, ifc.HSIZE);
        end
        tick(); // cycle 2
        checks++;
        if (ifc.HWDATA !== 64'hDEADBEEF_CAFEF00D || ifc.rsp_valid !== 1'b0 || ifc.HTRANS !== 2'b00) begin
            failures++;
            $display("FAIL wr_data hwdata=%h rsp_valid=%b htrans=%b exp deadbeefcafef00d/0/00",
                     ifc.HWDATA, ifc.rsp_valid, ifc.HTRANS);
        end
        tick(); // cycle 3
        checks++;
        if (ifc.rsp_valid !== 1'b1 || ifc.rsp_err !== 1'b0 || ifc.rsp_cancel !== 1'b0 ||
            ifc.rsp_rdata !== '0) begin
            failures++;
            $display("FAIL wr_rsp valid=%b err=%b cancel=%b rdata=%h exp 1/0/0/0",
                     ifc.rsp_valid, ifc.rsp_err, ifc.rsp_cancel, ifc.rsp_rdata);
        end
        tick(); // cycle 4
        checks++;
        if (ifc.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL wr_rsp_pulse valid=%b exp 0", ifc.rsp_valid);
        end
        $display("single_write: addr=0x1000 size=3 done");
    endtask

    // Read A (0x20) followed by read B (0x28); A's data phase waits 2 cycles
    // so B's address phase must be held through the wait.
    task automatic test_read_wait();
        drive_cmd(1'b1, 36'h20, 1'b0, 3'd2, '0);
        tick(); // cycle 1
        drive_cmd(1'b1, 36'h28, 1'b0, 3'd3, '0);
        checks++;
        if (ifc.HTRANS !== 2'b10 || ifc.HADDR !== 36'h20 || ifc.HWRITE !== 1'b0) begin
            failures++;
            $display("FAIL rd_addr htrans=%b haddr=%h hwrite=%b exp 10/20/0", ifc.HTRANS, ifc.HADDR, ifc.HWRITE);
        end
        tick(); // cycle 2: A data phase, B address phase
        drive_cmd(1'b0, '0, 1'b0, 3'd0, '0);
        ifc.HREADY = 1'b0;
        #1;
        checks++;
        if (ifc.cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL rd_ready_wait cmd_ready=%b exp 0", ifc.cmd_ready);
        end
        for (int c = 2; c <= 4; c++) begin
            checks++;
            if (ifc.HTRANS !== 2'b10 || ifc.HADDR !== 36'h28 || ifc.HSIZE !== 3'd3 || ifc.rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL rd_hold cyc=%0d htrans=%b haddr=%h hsize=%0d rsp_valid=%b exp 10/28/3/0",
                         c, ifc.HTRANS, ifc.HADDR, ifc.HSIZE, ifc.rsp_valid);
            end
            if (c < 4) tick();
            if (c == 3) begin
                ifc.HREADY = 1'b1;
                ifc.HRDATA = 64'h1234;
            end
        end
        tick(); // cycle 5
        ifc.HRDATA = 64'h5678;
        checks++;
        if (ifc.rsp_valid !== 1'b1 || ifc.rsp_rdata !== 64'h1234 || ifc.rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL rd_rsp_a valid=%b rdata=%h err=%b exp 1/1234/0", ifc.rsp_valid, ifc.rsp_rdata, ifc.rsp_err);
        end
        tick(); // cycle 6
        ifc.HRDATA = '0;
        checks++;
        if (ifc.rsp_valid !== 1'b1 || ifc.rsp_rdata !== 64'h5678 || ifc.rsp_cancel !== 1'b0) begin
            failures++;
            $display("FAIL rd_rsp_b valid=%b rdata=%h cancel=%b exp 1/5678/0", ifc.rsp_valid, ifc.rsp_rdata, ifc.rsp_cancel);
        end
        tick();
        $display("read_wait: rdata 0x1234 then 0x5678 done");
    endtask

    // Four commands on consecutive cycles. HRDATA carries 0x1111_0000 + c in
    // the cycle after edge c, so command j (data phase in cycle j+2) reads
    // 0x1111_0000 + j + 1 and responds in cycle j+3.
    task automatic test_back_to_back();
        logic [ADDR_W-1:0] addr  [4];
        logic              wr    [4];
        logic [DATA_W-1:0] wdata [4];
        logic [DATA_W-1:0] exp_r [4];
        addr[0] = 36'h100; wr[0] = 1'b1; wdata[0] = 64'hAAAA_0000_0000_0001; exp_r[0] = '0;
        addr[1] = 36'h108; wr[1] = 1'b0; wdata[1] = 64'h0;                   exp_r[1] = 64'h1111_0002;
        addr[2] = 36'h110; wr[2] = 1'b1; wdata[2] = 64'hBBBB_0000_0000_0003; exp_r[2] = '0;
        addr[3] = 36'h118; wr[3] = 1'b0; wdata[3] = 64'h0;                   exp_r[3] = 64'h1111_0004;
        for (int c = 0; c < 7; c++) begin
            if (c < 4) drive_cmd(1'b1, addr[c], wr[c], 3'(c), wdata[c]);
            else       drive_cmd(1'b0, '0, 1'b0, 3'd0, '0);
            tick();
            ifc.HRDATA = 64'h1111_0000 + 64'(c);
            checks++;
            if (c < 4) begin
                if (ifc.HTRANS !== 2'b10 || ifc.HADDR !== addr[c] || ifc.HWRITE !== wr[c]) begin
                    failures++;
                    $display("FAIL b2b_addr cmd=%0d htrans=%b haddr=%h exp 10/%h", c, ifc.HTRANS, ifc.HADDR, addr[c]);
                end
            end else if (ifc.HTRANS !== 2'b00) begin
                failures++;
                $display("FAIL b2b_idle cyc=%0d htrans=%b exp 00", c + 1, ifc.HTRANS);
            end
            if (c >= 1 && c <= 4) begin
                checks++;
                if (ifc.HWDATA !== wdata[c-1]) begin
                    failures++;
                    $display("FAIL b2b_hwdata cmd=%0d hwdata=%h exp %h", c - 1, ifc.HWDATA, wdata[c-1]);
                end
            end
            checks++;
            if (c >= 2 && c <= 5) begin
                if (ifc.rsp_valid !== 1'b1 || ifc.rsp_rdata !== exp_r[c-2] || ifc.rsp_err !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_rsp cmd=%0d valid=%b rdata=%h err=%b exp 1/%h/0",
                             c - 2, ifc.rsp_valid, ifc.rsp_rdata, ifc.rsp_err, exp_r[c-2]);
                end
            end else if (ifc.rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL b2b_norsp cyc=%0d valid=%b exp 0", c + 1, ifc.rsp_valid);
            end
        end
        ifc.HRDATA = '0;
        $display("back_to_back: 4 commands done");
    endtask

    // Write A then read B; ERROR on A must squash B into a cancel response.
    task automatic test_error_cancel();
        drive_cmd(1'b1, 36'h200, 1'b1, 3'd3, 64'h0123_4567_89AB_CDEF);
        tick(); // cycle 1
        drive_cmd(1'b1, 36'h208, 1'b0, 3'd3, '0);
        tick(); // cycle 2: first ERROR cycle
        drive_cmd(1'b0, '0, 1'b0, 3'd0, '0);
        ifc.HREADY = 1'b0;
        ifc.HRESP  = 2'b01;
        checks++;
        if (ifc.HTRANS !== 2'b10 || ifc.HADDR !== 36'h208) begin
            failures++;
            $display("FAIL err_b_addr htrans=%b haddr=%h exp 10/208", ifc.HTRANS, ifc.HADDR);
        end
        tick(); // cycle 3: second ERROR cycle
        ifc.HREADY = 1'b1;
        checks++;
        if (ifc.HTRANS !== 2'b00 || ifc.HWDATA !== 64'h0123_4567_89AB_CDEF || ifc.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL err_second htrans=%b hwdata=%h rsp_valid=%b exp 00/0123456789abcdef/0",
                     ifc.HTRANS, ifc.HWDATA, ifc.rsp_valid);
        end
        tick(); // cycle 4
        ifc.HRESP = 2'b00;
        checks++;
        if (ifc.rsp_valid !== 1'b1 || ifc.rsp_err !== 1'b1 || ifc.rsp_cancel !== 1'b0 ||
            ifc.rsp_rdata !== '0 || ifc.HTRANS !== 2'b00) begin
            failures++;
            $display("FAIL err_rsp_a valid=%b err=%b cancel=%b rdata=%h htrans=%b exp 1/1/0/0/00",
                     ifc.rsp_valid, ifc.rsp_err, ifc.rsp_cancel, ifc.rsp_rdata, ifc.HTRANS);
        end
        tick(); // cycle 5
        checks++;
        if (ifc.rsp_valid !== 1'b1 || ifc.rsp_err !== 1'b1 || ifc.rsp_cancel !== 1'b1 ||
            ifc.rsp_rdata !== '0 || ifc.HTRANS !== 2'b00) begin
            failures++;
            $display("FAIL err_rsp_b valid=%b err=%b cancel=%b rdata=%h htrans=%b exp 1/1/1/0/00",
                     ifc.rsp_valid, ifc.rsp_err, ifc.rsp_cancel, ifc.rsp_rdata, ifc.HTRANS);
        end
        tick(); // cycle 6
        checks++;
        if (ifc.rsp_valid !== 1'b0 || ifc.HTRANS !== 2'b00) begin
            failures++;
            $display("FAIL err_after valid=%b htrans=%b exp 0/00", ifc.rsp_valid, ifc.HTRANS);
        end
        $display("error_cancel: A err, B cancelled done");
    endtask

    // ERROR on a lone read: error response but no cancel afterwards.
    task automatic test_error_idle();
        drive_cmd(1'b1, 36'h400, 1'b0, 3'd1, '0);
        tick(); // cycle 1
        drive_cmd(1'b0, '0, 1'b0, 3'd0, '0);
        tick(); // cycle 2
        ifc.HREADY = 1'b0;
        ifc.HRESP  = 2'b01;
        ifc.HRDATA = 64'hFFFF;
        tick(); // cycle 3
        ifc.HREADY = 1'b1;
        tick(); // cycle 4
        ifc.HRESP  = 2'b00;
        ifc.HRDATA = '0;
        checks++;
        if (ifc.rsp_valid !== 1'b1 || ifc.rsp_err !== 1'b1 || ifc.rsp_cancel !== 1'b0) begin
            failures++;
            $display("FAIL erridle_rsp valid=%b err=%b cancel=%b exp 1/1/0", ifc.rsp_valid, ifc.rsp_err, ifc.rsp_cancel);
        end
        tick(); // cycle 5
        checks++;
        if (ifc.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL erridle_nocancel valid=%b exp 0", ifc.rsp_valid);
        end
        $display("error_idle: no cancel done");
    endtask

    task automatic test_reset_mid_wait();
        drive_cmd(1'b1, 36'h300, 1'b0, 3'd3, '0);
        tick(); // cycle 1
        drive_cmd(1'b1, 36'h308, 1'b0, 3'd3, '0);
        tick(); // cycle 2: read waiting, second command in address phase
        drive_cmd(1'b0, '0, 1'b0, 3'd0, '0);
        ifc.HREADY = 1'b0;
        HRESET = 1'b1;
        tick(); // cycle 3
        checks++;
        if (ifc.HTRANS !== 2'b00 || ifc.HADDR !== '0 || ifc.HSIZE !== 3'd0 || ifc.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstwait_bus htrans=%b haddr=%h hsize=%0d rsp_valid=%b exp 00/0/0/0",
                     ifc.HTRANS, ifc.HADDR, ifc.HSIZE, ifc.rsp_valid);
        end
        HRESET = 1'b0;
        ifc.HREADY = 1'b1;
        ifc.HRDATA = 64'h9999;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (ifc.rsp_valid !== 1'b0 || ifc.HTRANS !== 2'b00) begin
                failures++;
                $display("FAIL rstwait_norsp cyc=%0d valid=%b htrans=%b exp 0/00", i, ifc.rsp_valid, ifc.HTRANS);
            end
        end
        ifc.HRDATA = '0;
        $display("reset_mid_wait: done");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        HRESET   = 1'b1;
        ifc.HREADY = 1'b1;
        ifc.HRESP  = 2'b00;
        ifc.HRDATA = '0;
        drive_cmd(1'b0, '0, 1'b0, 3'd0, '0);
        test_reset();
        test_single_write();
        test_read_wait();
        test_back_to_back();
        test_error_cancel();
        test_error_idle();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
